button_event_decoder: RTL
=========================

Name: button_event_decoder

Overview:
Sits directly downstream of the contact debouncer and consumes its clean, sync-aligned button level. Classifies each press into single-cycle event pulses: press, release, short press, long press and auto-repeat. Hold time is measured in ticks of the same external sync timer that drives the debouncer, so all durations share one time base. Outputs feed the menu/control logic as one-clock strobes.

Parameters:
CNT_W, 8, width of hold/repeat tick counter; must hold max(LONG_TICKS, REPEAT_TICKS)-1
LONG_TICKS, 100, sync ticks of continuous hold before long_press fires (>=1)
REPEAT_TICKS, 20, sync ticks between repeat strobes once in long hold (>=1)
REPEAT_EN, 1, 1 = generate repeat strobes; 0 = repeat held at 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sync  in  1  one-clk tick from external timer; same signal as the debouncer's
btn  in  1  debounced button level, 1 = pressed
press  out  1  one-clk pulse on press edge
release  out  1  one-clk pulse on release edge
short_press  out  1  one-clk pulse on release when long threshold not reached
long_press  out  1  one-clk pulse when hold reaches LONG_TICKS
repeat  out  1  one-clk pulse every REPEAT_TICKS while in long hold
held  out  1  level, 1 while state != IDLE

Behaviour:
- Single clock domain clk; reset synchronous, active-high, sampled on posedge clk only.
- Reset: state=IDLE, cnt=0, btn_q=1, all outputs 0. btn_q resets to 1, so a button held through reset is not reported; it must be released first (the fall is ignored in IDLE).
- Every clk: btn_q <= btn; rise = btn & ~btn_q; fall = ~btn & btn_q.
- All outputs are registered. Each event pulse is high for exactly one cycle, in the cycle after the edge where its condition is evaluated. Latency from btn change to press/release/short_press is 1 clk.
- IDLE:
  - on rise: go to PRESSED, cnt <= 0, pulse press.
  - fall in IDLE is ignored.
- PRESSED:
  - on fall: go to IDLE, pulse release and short_press in the same cycle.
  - else on sync: if cnt == LONG_TICKS-1, go to LONG_HELD, cnt <= 0, pulse long_press; otherwise cnt++.
- LONG_HELD:
  - on fall: go to IDLE, pulse release only (no short_press).
  - else on sync with REPEAT_EN=1: if cnt == REPEAT_TICKS-1, pulse repeat and cnt <= 0; otherwise cnt++.
  - with REPEAT_EN=0: cnt frozen, repeat never asserts.
- Simultaneous fall and sync: fall wins; no long_press or repeat is issued on that edge.
- Counting granularity: hold time is counted in sync ticks after the press edge. The first sync in PRESSED counts as tick 1, so long_press fires on the LONG_TICKS-th sync after press.
- held: registered. It rises together with press and falls together with release.
- rst asserted mid-press: immediate return to IDLE, no release/short_press emitted, btn_q=1.
- Counter never wraps: it is cleared on the threshold match, and widths are checked by an elaboration-time assertion.
- State encoding: IDLE=2'd0, PRESSED=2'd1, LONG_HELD=2'd2; 2'd3 is unreachable and recovers to IDLE on the next clk.

Decomposition:
- Package btn_event_pkg holds the state encoding constants (ST_IDLE, ST_PRESSED, ST_LONG_HELD) and the default tick constants, so the menu logic can share them.
- One natural sub-module: edge_detect (btn_q register, rise/fall outputs, reset value parameter RST_VAL=1). It is reusable for other debounced inputs.
- Counter and FSM stay in the top module.

Test Plan:
All scenarios use LONG_TICKS=4, REPEAT_TICKS=2 and sync every 4 clk unless noted.
1. Short tap: btn high for 2 sync ticks, then low -> press 1 clk after rise; release+short_press together 1 clk after fall; long_press and repeat never assert; held high for exactly the pressed span.
2. Long hold: btn high for 9 sync ticks -> long_press on the 4th sync after press; repeat on the 6th and 8th syncs; on release, release only (no short_press).
3. REPEAT_EN=0, btn high for 10 syncs -> single long_press, repeat stays 0, release on fall.
4. Fall coincident with the 4th sync -> release+short_press; long_press never asserts.
5. btn held high across deassertion of rst -> no press; after btn falls and rises again, press fires normally.
6. rst asserted while in LONG_HELD -> all outputs 0 next clk, no release pulse, held=0; state returns to IDLE.

Source files
------------

// File: rtl/btn_event_pkg.sv
// Shared constants for the button event decoder and the menu logic that consumes it:
// state encoding, default tick thresholds and the event strobe bundle.
package btn_event_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESSED   = 2'd1;
  localparam logic [1:0] ST_LONG_HELD = 2'd2;

  localparam int CNT_W_DEF        = 8;
  localparam int LONG_TICKS_DEF   = 100;
  localparam int REPEAT_TICKS_DEF = 20;

  typedef struct packed {
    logic press;
    logic rel;
    logic short_press;
    logic long_press;
    logic rpt;
  } btn_events_t;

  localparam btn_events_t EVENTS_NONE = '0;

  function automatic int max_ticks(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers a debounced level and reports its rising and falling edges combinationally.
// RST_VAL = 1 hides a level that is already high when reset releases.
module edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= RST_VAL;
    else       r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;
  assign o_fall = ~i_d & r_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-clock press/release/short/long/repeat strobes,
// timing the hold in ticks of the shared sync timer.
module button_event_decoder
  import btn_event_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sync,
  input  logic i_btn,
  output logic o_press,
  output logic o_release,
  output logic o_short_press,
  output logic o_long_press,
  output logic o_repeat,
  output logic o_held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  if (LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_ticks
    $error("button_event_decoder: LONG_TICKS and REPEAT_TICKS must be >= 1");
  end
  if (longint'(max_ticks(LONG_TICKS, REPEAT_TICKS) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_width
    $error("button_event_decoder: CNT_W too narrow for the tick thresholds");
  end

  logic        w_rise;
  logic        w_fall;
  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  btn_events_t r_evt;
  btn_events_t w_evt;
  logic        r_held;

  edge_detect #(.RST_VAL(1'b1)) u_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_btn),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // A fall always beats a coincident sync, so no threshold event fires on the release edge.
  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_evt       = EVENTS_NONE;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
          w_evt.press = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (w_fall) begin
          w_state_nxt       = ST_IDLE;
          w_cnt_nxt         = '0;
          w_evt.rel         = 1'b1;
          w_evt.short_press = 1'b1;
        end else if (i_sync) begin
          if (r_cnt == LONG_LAST) begin
            w_state_nxt      = ST_LONG_HELD;
            w_cnt_nxt        = '0;
            w_evt.long_press = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_LONG_HELD: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_evt.rel   = 1'b1;
        end else if (i_sync && REPEAT_EN) begin
          if (r_cnt == REPEAT_LAST) begin
            w_cnt_nxt = '0;
            w_evt.rpt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_evt   <= EVENTS_NONE;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_evt   <= w_evt;
      r_held  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_press       = r_evt.press;
  assign o_release     = r_evt.rel;
  assign o_short_press = r_evt.short_press;
  assign o_long_press  = r_evt.long_press;
  assign o_repeat      = r_evt.rpt;
  assign o_held        = r_held;

endmodule
